// File: rtl/inta_bus_sequencer.sv
// -----------------------------------------------------------------------------
// inta_bus_sequencer
//
// Sequences the PIC data bus buffer during interrupt-acknowledge cycles and
// CPU register reads. It counts INTA pulses (two in 8086 mode, three in 8080
// mode) and supplies the byte for each pulse. It also drives the buffer output
// enable, freezes the priority resolver for the length of a sequence, and tells
// the in-service register which IRQ to set.
//
// Optional feature macro: PIC_AEOI_EN
//   defined   : eoi_pulse fires together with ack_done when the aeoi bit
//               latched at the first INTA edge is 1
//   undefined : eoi_pulse is tied low and the aeoi input is ignored
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   inta_n       in   CPU interrupt acknowledge (async, active-low)
//   cs_n         in   chip select (async, active-low)
//   rd_n         in   CPU read strobe (async, active-low)
//   mode_8086    in   1 = 8086 (2 pulses), 0 = 8080 (3 pulses)
//   irq_valid    in   priority resolver holds a pending IRQ
//   highest_irq  in   [2:0]  winning IRQ index
//   vector_base  in   [4:0]  T7..T3 of the 8086 vector
//   call_addr    in   [15:0] 8080 CALL address, bits [7:5] and [15:8] used
//   aeoi         in   automatic-EOI mode bit
//   status_data  in   [7:0]  register byte for CPU reads
//   out_data     out  [7:0]  byte presented to the bus buffer
//   buf_enable   out  buffer drives the data bus
//   freeze       out  holds the priority resolver during a sequence
//   isr_set      out  one-cycle pulse setting ISR bit isr_index
//   isr_index    out  [2:0]  IRQ being acknowledged
//   ack_done     out  one-cycle pulse after the final INTA pulse
//   eoi_pulse    out  automatic EOI strobe
// -----------------------------------------------------------------------------
module inta_bus_sequencer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        inta_n,
   input  logic        cs_n,
   input  logic        rd_n,
   input  logic        mode_8086,
   input  logic        irq_valid,
   input  logic [2:0]  highest_irq,
   input  logic [4:0]  vector_base,
   input  logic [15:0] call_addr,
   input  logic        aeoi,
   input  logic [7:0]  status_data,
   output logic [7:0]  out_data,
   output logic        buf_enable,
   output logic        freeze,
   output logic        isr_set,
   output logic [2:0]  isr_index,
   output logic        ack_done,
   output logic        eoi_pulse
);

   typedef enum logic [2:0] {IDLE, P1, G1, P2, G2, P3} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] inta_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] rd_sync;
   logic                   inta_s;
   logic                   cs_s;
   logic                   rd_s;
   logic                   inta_d;
   logic                   inta_fall;
   logic                   inta_rise;
   logic                   mode_l;
   logic [2:0]             ack_irq;
   logic                   eoi_next;
   logic                   unused_call_bits;

   assign unused_call_bits = ^call_addr[4:0];

   // Synchronizers preset to 1 so that reset looks like all strobes inactive.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inta_sync <= '1;
         cs_sync   <= '1;
         rd_sync   <= '1;
         inta_d    <= 1'b1;
      end else begin
         inta_sync <= {inta_sync[SYNC_STAGES-2:0], inta_n};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         rd_sync   <= {rd_sync[SYNC_STAGES-2:0], rd_n};
         inta_d    <= inta_s;
      end
   end

   assign inta_s    = inta_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign rd_s      = rd_sync[SYNC_STAGES-1];
   assign inta_fall = inta_d & ~inta_s;
   assign inta_rise = ~inta_d & inta_s;

`ifdef PIC_AEOI_EN
   logic aeoi_l;

   // The aeoi bit is captured with the first INTA edge so that a mid-sequence
   // ICW4 rewrite cannot change how this acknowledge finishes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         aeoi_l <= 1'b0;
      else if (state == IDLE && inta_fall)
         aeoi_l <= aeoi;
   end

   assign eoi_next = aeoi_l;
`else
   logic unused_aeoi;

   assign unused_aeoi = aeoi;
   assign eoi_next    = 1'b0;
`endif

   assign isr_index = ack_irq;

   // Main sequencer. Every output is a register updated here; an INTA edge in
   // IDLE takes precedence over a register read so a read is aborted cleanly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         mode_l     <= 1'b0;
         ack_irq    <= 3'd0;
         out_data   <= 8'h00;
         buf_enable <= 1'b0;
         freeze     <= 1'b0;
         isr_set    <= 1'b0;
         ack_done   <= 1'b0;
         eoi_pulse  <= 1'b0;
      end else begin
         isr_set   <= 1'b0;
         ack_done  <= 1'b0;
         eoi_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (inta_fall) begin
                  mode_l <= mode_8086;
                  freeze <= 1'b1;
                  state  <= P1;
                  if (irq_valid) begin
                     ack_irq <= highest_irq;
                     isr_set <= 1'b1;
                  end else begin
                     ack_irq <= 3'd7;
                  end
                  if (mode_8086) begin
                     buf_enable <= 1'b0;
                  end else begin
                     buf_enable <= 1'b1;
                     out_data   <= 8'hCD;
                  end
               end else if (!cs_s && !rd_s) begin
                  buf_enable <= 1'b1;
                  out_data   <= status_data;
               end else begin
                  buf_enable <= 1'b0;
               end
            end
            P1: begin
               if (inta_rise) begin
                  state      <= G1;
                  buf_enable <= 1'b0;
               end
            end
            G1: begin
               if (inta_fall) begin
                  state      <= P2;
                  buf_enable <= 1'b1;
                  if (mode_l)
                     out_data <= {vector_base, ack_irq};
                  else
                     out_data <= {call_addr[7:5], ack_irq, 2'b00};
               end
            end
            P2: begin
               if (inta_rise) begin
                  buf_enable <= 1'b0;
                  if (mode_l) begin
                     state     <= IDLE;
                     freeze    <= 1'b0;
                     ack_done  <= 1'b1;
                     eoi_pulse <= eoi_next;
                  end else begin
                     state <= G2;
                  end
               end
            end
            G2: begin
               if (inta_fall) begin
                  state      <= P3;
                  buf_enable <= 1'b1;
                  out_data   <= call_addr[15:8];
               end
            end
            P3: begin
               if (inta_rise) begin
                  state      <= IDLE;
                  buf_enable <= 1'b0;
                  freeze     <= 1'b0;
                  ack_done   <= 1'b1;
                  eoi_pulse  <= eoi_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inta_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inta_bus_sequencer
//
// Directed bench for inta_bus_sequencer. Expected bus bytes are queued when an
// INTA edge is driven and popped once the response is due. One-cycle pulses
// (isr_set, ack_done, eoi_pulse) are tallied by a monitor.
// -----------------------------------------------------------------------------
module tb_inta_bus_sequencer;

   localparam int SYNC = 2;
   localparam int LAT  = SYNC + 1;

   logic        clk;
   logic        reset_n;
   logic        inta_n;
   logic        cs_n;
   logic        rd_n;
   logic        mode_8086;
   logic        irq_valid;
   logic [2:0]  highest_irq;
   logic [4:0]  vector_base;
   logic [15:0] call_addr;
   logic        aeoi;
   logic [7:0]  status_data;
   logic [7:0]  out_data;
   logic        buf_enable;
   logic        freeze;
   logic        isr_set;
   logic [2:0]  isr_index;
   logic        ack_done;
   logic        eoi_pulse;

   typedef struct {
      string      tag;
      logic       en;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   isr_set_cnt = 0;
   int   ack_done_cnt = 0;
   int   eoi_cnt = 0;
   int   eoi_with_ack_cnt = 0;
   int   snap;
   logic exp_eoi;

   inta_bus_sequencer #(.SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .inta_n      (inta_n),
      .cs_n        (cs_n),
      .rd_n        (rd_n),
      .mode_8086   (mode_8086),
      .irq_valid   (irq_valid),
      .highest_irq (highest_irq),
      .vector_base (vector_base),
      .call_addr   (call_addr),
      .aeoi        (aeoi),
      .status_data (status_data),
      .out_data    (out_data),
      .buf_enable  (buf_enable),
      .freeze      (freeze),
      .isr_set     (isr_set),
      .isr_index   (isr_index),
      .ack_done    (ack_done),
      .eoi_pulse   (eoi_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse tally: each cycle's registered value is seen at the following edge.
   always @(posedge clk) begin
      if (isr_set)   isr_set_cnt  <= isr_set_cnt + 1;
      if (ack_done)  ack_done_cnt <= ack_done_cnt + 1;
      if (eoi_pulse) eoi_cnt      <= eoi_cnt + 1;
      if (eoi_pulse && ack_done) eoi_with_ack_cnt <= eoi_with_ack_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_bus(input string tag, input logic en, input logic [7:0] data);
      exp_t item;
      item.tag  = tag;
      item.en   = en;
      item.data = data;
      exp_q.push_back(item);
   endtask

   task automatic check_bus();
      exp_t item;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         item = exp_q.pop_front();
         check({item.tag, "_en"}, {15'd0, buf_enable}, {15'd0, item.en});
         if (item.en)
            check({item.tag, "_data"}, {8'd0, out_data}, {8'd0, item.data});
      end
   endtask

   // Drive one INTA edge, queue the expected bus state, and check it once due.
   task automatic inta_edge(input logic level, input string tag, input logic en,
                            input logic [7:0] data);
      inta_n = level;
      expect_bus(tag, en, data);
      tick(LAT);
      check_bus();
   endtask

   initial begin
`ifdef PIC_AEOI_EN
      exp_eoi = 1'b1;
`else
      exp_eoi = 1'b0;
`endif
      reset_n     = 1'b0;
      inta_n      = 1'b1;
      cs_n        = 1'b1;
      rd_n        = 1'b1;
      mode_8086   = 1'b1;
      irq_valid   = 1'b0;
      highest_irq = 3'd0;
      vector_base = 5'd0;
      call_addr   = 16'h0000;
      aeoi        = 1'b0;
      status_data = 8'h00;
      tick(2);
      check("rst_buf_enable", {15'd0, buf_enable}, 16'd0);
      check("rst_freeze", {15'd0, freeze}, 16'd0);
      check("rst_out_data", {8'd0, out_data}, 16'd0);
      check("rst_isr_index", {13'd0, isr_index}, 16'd0);
      check("rst_pulses", {13'd0, isr_set, ack_done, eoi_pulse}, 16'd0);
      reset_n = 1'b1;
      tick(2);

      // 8086 acknowledge of IRQ3 with AEOI requested
      mode_8086   = 1'b1;
      irq_valid   = 1'b1;
      highest_irq = 3'd3;
      vector_base = 5'b01000;
      aeoi        = 1'b1;
      inta_edge(1'b0, "a86_p1", 1'b0, 8'h00);
      check("a86_freeze", {15'd0, freeze}, 16'd1);
      check("a86_isr_index", {13'd0, isr_index}, 16'd3);
      highest_irq = 3'd6;
      mode_8086   = 1'b0;
      inta_edge(1'b1, "a86_g1", 1'b0, 8'h00);
      inta_edge(1'b0, "a86_p2", 1'b1, 8'h43);
      inta_edge(1'b1, "a86_end", 1'b0, 8'h00);
      check("a86_ack_done", {15'd0, ack_done}, 16'd1);
      check("a86_freeze_end", {15'd0, freeze}, 16'd0);
      tick(1);
      check("a86_isr_set_cnt", isr_set_cnt[15:0], 16'd1);
      check("a86_ack_cnt", ack_done_cnt[15:0], 16'd1);
      check("a86_eoi_cnt", eoi_cnt[15:0], {15'd0, exp_eoi});
      check("a86_eoi_with_ack", eoi_with_ack_cnt[15:0], {15'd0, exp_eoi});

      // 8080 acknowledge of IRQ5, no AEOI
      aeoi        = 1'b0;
      mode_8086   = 1'b0;
      highest_irq = 3'd5;
      call_addr   = 16'h12A0;
      snap        = eoi_cnt;
      inta_edge(1'b0, "a80_p1", 1'b1, 8'hCD);
      check("a80_isr_index", {13'd0, isr_index}, 16'd5);
      inta_edge(1'b1, "a80_g1", 1'b0, 8'h00);
      inta_edge(1'b0, "a80_p2", 1'b1, 8'hB4);
      inta_edge(1'b1, "a80_g2", 1'b0, 8'h00);
      check("a80_freeze_mid", {15'd0, freeze}, 16'd1);
      inta_edge(1'b0, "a80_p3", 1'b1, 8'h12);
      inta_edge(1'b1, "a80_end", 1'b0, 8'h00);
      check("a80_ack_done", {15'd0, ack_done}, 16'd1);
      tick(1);
      check("a80_ack_cnt", ack_done_cnt[15:0], 16'd2);
      check("a80_no_eoi", eoi_cnt[15:0], snap[15:0]);

      // Spurious acknowledge: IR7 vector, no ISR set
      mode_8086   = 1'b1;
      irq_valid   = 1'b0;
      vector_base = 5'b00001;
      snap        = isr_set_cnt;
      inta_edge(1'b0, "spur_p1", 1'b0, 8'h00);
      check("spur_isr_index", {13'd0, isr_index}, 16'd7);
      inta_edge(1'b1, "spur_g1", 1'b0, 8'h00);
      inta_edge(1'b0, "spur_p2", 1'b1, 8'h0F);
      inta_edge(1'b1, "spur_end", 1'b0, 8'h00);
      tick(1);
      check("spur_no_isr_set", isr_set_cnt[15:0], snap[15:0]);

      // Register read
      status_data = 8'h5A;
      cs_n        = 1'b0;
      rd_n        = 1'b0;
      expect_bus("rd_active", 1'b1, 8'h5A);
      tick(LAT);
      check_bus();
      status_data = 8'hC3;
      expect_bus("rd_update", 1'b1, 8'hC3);
      tick(1);
      check_bus();
      rd_n = 1'b1;
      tick(SYNC);
      check("rd_still_on", {15'd0, buf_enable}, 16'd1);
      tick(1);
      check("rd_released", {15'd0, buf_enable}, 16'd0);
      cs_n = 1'b1;
      tick(2);

      // Read aborted by INTA, then reset in P2
      status_data = 8'h5A;
      cs_n        = 1'b0;
      rd_n        = 1'b0;
      tick(LAT);
      mode_8086   = 1'b0;
      irq_valid   = 1'b1;
      highest_irq = 3'd2;
      call_addr   = 16'h12A0;
      inta_edge(1'b0, "abort_p1", 1'b1, 8'hCD);
      check("abort_freeze", {15'd0, freeze}, 16'd1);
      cs_n = 1'b1;
      rd_n = 1'b1;
      inta_edge(1'b1, "abort_g1", 1'b0, 8'h00);
      inta_edge(1'b0, "abort_p2", 1'b1, 8'hA8);
      #1;
      reset_n = 1'b0;
      #1;
      check("rstmid_buf_enable", {15'd0, buf_enable}, 16'd0);
      check("rstmid_freeze", {15'd0, freeze}, 16'd0);
      check("rstmid_out_data", {8'd0, out_data}, 16'd0);
      inta_n = 1'b1;
      tick(2);
      reset_n = 1'b1;
      tick(2);
      check("post_rst_idle", {15'd0, buf_enable}, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
